// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART register map, parity modes and TX state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [3:0] ADDR_PARITY = 4'b0101;
    localparam logic [3:0] ADDR_STOP   = 4'b0110;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } tx_state_t;

    // Register encoding: 00/01 none, 10 even, 11 odd.
    function automatic parity_mode_t decode_parity(input logic [1:0] sel);
        case (sel)
            2'b10:   return PAR_EVEN;
            2'b11:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Synchronous FIFO for the UART transmitter; a pop frees a slot
//            for a same-cycle push even when full. DEPTH must be a power of 2.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_serial_tx
// Purpose  : UART transmitter: start, 8 data bits LSB first, optional parity,
//            1 or 2 stop bits. Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry
//            TX FIFO instead of the single holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_serial_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       c_valid,
    input  logic [3:0] c_addr,
    input  logic [7:0] c_data,
    output logic       c_ready,
    output logic       out,
    output logic       busy
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]   r_idx;
    logic [7:0]   r_shift;
    logic         r_par_bit;
    logic         r_par_en_sh;
    logic         r_stop2_sh;
    parity_mode_t r_par_mode;
    logic         r_stop2;
    logic         r_out;

    logic       w_bit_done;
    logic       w_frame_end;
    logic       w_avail;
    logic [7:0] w_byte;
    logic       w_start;
    logic       w_pending;
    logic       w_cfg_wr;
    logic       w_unused_bits;

    assign w_bit_done  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_bit_done &&
                         ((r_state == STOP1 && !r_stop2_sh) || r_state == STOP2);
    // A new frame starts from IDLE or seamlessly from the last stop bit.
    assign w_start     = w_avail && (r_state == IDLE || w_frame_end);
    assign busy        = (r_state != IDLE) || w_pending;
    assign c_ready     = !busy;
    assign w_cfg_wr    = c_valid && c_ready;
    assign out         = r_out;
    assign w_unused_bits = &{1'b0, c_data[7:2], FIFO_DEPTH[0]};

`ifdef UART_TX_FIFO_EN
    logic       w_fifo_empty;
    logic       w_fifo_full;
    logic [7:0] w_fifo_head;
    logic       w_pop;
    logic       w_push;

    // An empty FIFO is bypassed so an idle line starts on the next cycle.
    assign w_avail   = !w_fifo_empty || in_valid;
    assign w_byte    = w_fifo_empty ? in_data : w_fifo_head;
    assign w_pop     = w_start && !w_fifo_empty;
    assign w_push    = in_valid && in_ready && !(w_start && w_fifo_empty);
    assign in_ready  = !w_fifo_full || w_pop;
    assign w_pending = !w_fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );
`else
    logic [7:0] r_hold;
    logic       r_hold_full;

    // An empty holding register is bypassed so an idle line starts next cycle.
    assign w_avail   = r_hold_full || in_valid;
    assign w_byte    = r_hold_full ? r_hold : in_data;
    assign in_ready  = !r_hold_full;
    assign w_pending = r_hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_start && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (in_valid && !r_hold_full && !w_start) begin
            r_hold      <= in_data;
            r_hold_full <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_par_en_sh <= 1'b0;
            r_stop2_sh  <= 1'b0;
            r_par_mode  <= PAR_NONE;
            r_stop2     <= 1'b0;
            r_out       <= 1'b1;
        end else begin
            if (w_cfg_wr) begin
                if (c_addr == ADDR_PARITY)    r_par_mode <= decode_parity(c_data[1:0]);
                else if (c_addr == ADDR_STOP) r_stop2    <= c_data[0];
            end

            // Byte, parity and frame format are all frozen at START entry.
            if (w_start) begin
                r_state     <= START;
                r_cnt       <= '0;
                r_idx       <= '0;
                r_shift     <= w_byte;
                r_par_bit   <= (^w_byte) ^ (r_par_mode == PAR_ODD);
                r_par_en_sh <= (r_par_mode != PAR_NONE);
                r_stop2_sh  <= r_stop2;
                r_out       <= 1'b0;
            end else if (r_state != IDLE) begin
                if (!w_bit_done) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_cnt <= '0;
                    case (r_state)
                        START: begin
                            r_state <= DATA;
                            r_out   <= r_shift[0];
                        end
                        DATA: begin
                            if (r_idx == 3'd7) begin
                                r_state <= r_par_en_sh ? PARITY : STOP1;
                                r_out   <= r_par_en_sh ? r_par_bit : 1'b1;
                            end else begin
                                r_idx <= r_idx + 3'd1;
                                r_out <= r_shift[r_idx + 3'd1];
                            end
                        end
                        PARITY: begin
                            r_state <= STOP1;
                            r_out   <= 1'b1;
                        end
                        STOP1: begin
                            r_state <= r_stop2_sh ? STOP2 : IDLE;
                            r_out   <= 1'b1;
                        end
                        default: begin
                            r_state <= IDLE;
                            r_out   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_serial_tx
// Purpose  : Self-checking bench for uart_serial_tx: table vectors, directed
//            corner sequences and randomized frames against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_serial_tx;

    localparam int CPB   = 16;
    localparam int LIMIT = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       c_valid = 1'b0;
    logic [3:0] c_addr = '0;
    logic [7:0] c_data = '0;
    logic       c_ready;
    logic       out;
    logic       busy;

    uart_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .c_valid  (c_valid),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_ready  (c_ready),
        .out      (out),
        .busy     (busy)
    );

    always #37 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected line level per bit period, consumed by the monitor.
    bit exp_q[$];
    int phase  = 0;
    int good   = 0;
    int bit_no = 0;

    // Bench view of the frame configuration.
    bit cfg_par_en = 1'b0;
    bit cfg_odd    = 1'b0;
    bit cfg_stop2  = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endfunction

    function automatic void push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (cfg_par_en) exp_q.push_back((^d) ^ cfg_odd);
        exp_q.push_back(1'b1);
        if (cfg_stop2) exp_q.push_back(1'b1);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            if (out === exp_q[0] && busy === 1'b1) good++;
            phase++;
            if (phase == CPB) begin
                check($sformatf("line_bit%0d", bit_no), good, CPB);
                void'(exp_q.pop_front());
                phase = 0;
                good  = 0;
                bit_no++;
            end
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d, input bit blocked);
        int t;
        @(negedge clk);
        c_valid = 1'b1;
        c_addr  = a;
        c_data  = d;
        if (blocked) check("cfg_blocked_c_ready", c_ready, 0);
        t = 0;
        while (c_ready !== 1'b1 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) fail_timeout("cfg_wait");
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        if (a == 4'b0101) begin
            cfg_par_en = d[1];
            cfg_odd    = d[0];
        end else if (a == 4'b0110) begin
            cfg_stop2 = d[0];
        end
    endtask

    // Leaves in_valid high so a following send forms a back-to-back pair.
    task automatic send(input logic [7:0] d, input bit model);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (in_ready !== 1'b1 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) fail_timeout("send_wait");
        @(posedge clk);
        #1;
        if (model) push_frame(d);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) begin
            fail_timeout("frame_drain");
            exp_q.delete();
            phase = 0;
            good  = 0;
        end
        @(negedge clk);
        check("idle_out", out, 1);
        check("idle_busy", busy, 0);
        check("idle_c_ready", c_ready, 1);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  par_cfg;
        logic [7:0]  stop_cfg;
        logic [11:0] frame;
        int          len;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #(74 * 90000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [7:0] d;
        logic [7:0] d2;
        logic [3:0] a;

        // Frames listed in transmit order: bit 0 is the start bit.
        vecs[0] = '{8'hA5, 8'h00, 8'h00, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
        vecs[1] = '{8'hA5, 8'h02, 8'h00, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        vecs[2] = '{8'hA5, 8'h03, 8'h00, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
        vecs[3] = '{8'h00, 8'h00, 8'h01, {1'b0, 2'b11, 8'h00, 1'b0}, 11};
        vecs[4] = '{8'h3C, 8'h02, 8'hFF, {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}, 12};
        vecs[5] = '{8'h07, 8'hF3, 8'h00, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11};
        vecs[6] = '{8'h80, 8'h01, 8'hFE, {2'b00, 1'b1, 8'h80, 1'b0}, 10};
        vecs[7] = '{8'h6E, 8'h02, 8'h01, {1'b1, 1'b1, 1'b1, 8'h6E, 1'b0}, 12};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", out, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_c_ready", c_ready, 1);
        rst = 1'b0;

        // Table-driven frames.
        for (int v = 0; v < 8; v++) begin
            cfg_write(4'b0101, vecs[v].par_cfg, 1'b0);
            cfg_write(4'b0110, vecs[v].stop_cfg, 1'b0);
            send(vecs[v].data, 1'b0);
            in_valid = 1'b0;
            for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(vecs[v].frame[i]);
            wait_drain();
        end

        // Back-to-back: second start bit follows the first frame with no gap.
        cfg_write(4'b0101, 8'h00, 1'b0);
        cfg_write(4'b0110, 8'h00, 1'b0);
        send(8'h55, 1'b1);
        send(8'hFF, 1'b1);
        @(negedge clk);
        check("b2b_in_ready", in_ready, 0);
        check("b2b_busy", busy, 1);
        in_valid = 1'b0;
        wait_drain();

        // Config write mid-frame waits for idle and applies to the next frame.
        send(8'hA5, 1'b1);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        cfg_write(4'b0101, 8'h02, 1'b1);
        send(8'h07, 1'b1);
        in_valid = 1'b0;
        wait_drain();

        // Reset during data bit 4 of 8'hC3 with 8'h5A pending.
        cfg_write(4'b0101, 8'h00, 1'b0);
        send(8'hC3, 1'b0);
        send(8'h5A, 1'b0);
        in_valid = 1'b0;
        repeat (84) @(negedge clk);
        check("pre_reset_line", out, 0);
        check("pre_reset_in_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out", out, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_c_ready", c_ready, 1);
        rst = 1'b0;
        cfg_par_en = 1'b0;
        cfg_odd    = 1'b0;
        cfg_stop2  = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (out !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no_pending_after_rst", bad, 0);

        // Randomized frames, formats and ignored register writes.
        for (int i = 0; i < 14; i++) begin
            d  = 8'($urandom);
            d2 = 8'($urandom);
            a  = 4'($urandom);
            if (a == 4'b0101 || a == 4'b0110) a = 4'h0;
            cfg_write(4'b0101, 8'($urandom), 1'b0);
            cfg_write(4'b0110, 8'($urandom), 1'b0);
            cfg_write(a, 8'($urandom), 1'b0);
            send(d, 1'b1);
            if ($urandom_range(0, 1) == 1) send(d2, 1'b1);
            in_valid = 1'b0;
            wait_drain();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
